// File: rtl/reg_file_mp.sv
// Multi-port register file: two registered read ports, byte-strobed write port, and a
// zeroing sweep triggered by reset or clear. Optional forwarding: REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [ADDR_W-1:0]     raddr_a,
    output logic [DATA_W-1:0]     rdata_a,
    input  logic [ADDR_W-1:0]     raddr_b,
    output logic [DATA_W-1:0]     rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic                busy_r;
    logic [DATA_W-1:0]   rdata_a_r;
    logic [DATA_W-1:0]   rdata_b_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                wr_ok_s;
    logic [DATA_W-1:0]   merged_s;
    logic [DATA_W-1:0]   rd_a_s;
    logic [DATA_W-1:0]   rd_b_s;

    // New bytes where the strobe is set, old bytes elsewhere.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NB-1:0]     strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 == 1) && (a == {ADDR_W{1'b0}});
    endfunction

    // Write acceptance and merged write value.
    always_comb begin
        wr_ok_s  = 1'b0;
        merged_s = byte_merge(mem_r[waddr], wdata, wstrb);
        if (we && !rst && (state_r == IDLE) && (wstrb != {NB{1'b0}}) && !is_zero_reg(waddr)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Read data for both ports, optionally forwarding the accepted write.
    always_comb begin
        rd_a_s = mem_r[raddr_a];
        rd_b_s = mem_r[raddr_b];
        if (is_zero_reg(raddr_a)) begin
            rd_a_s = {DATA_W{1'b0}};
`ifdef REG_FILE_MP_BYPASS_EN
        end else if (wr_ok_s && (waddr == raddr_a)) begin
            rd_a_s = merged_s;
`endif
        end else begin
            rd_a_s = mem_r[raddr_a];
        end
        if (is_zero_reg(raddr_b)) begin
            rd_b_s = {DATA_W{1'b0}};
`ifdef REG_FILE_MP_BYPASS_EN
        end else if (wr_ok_s && (waddr == raddr_b)) begin
            rd_b_s = merged_s;
`endif
        end else begin
            rd_b_s = mem_r[raddr_b];
        end
    end

    // Sweep FSM, busy flag and registered read data; rdata is forced to 0 while sweeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= SWEEP;
            cnt_r     <= {ADDR_W{1'b0}};
            busy_r    <= 1'b1;
            rdata_a_r <= {DATA_W{1'b0}};
            rdata_b_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (clear) begin
                        state_r   <= SWEEP;
                        cnt_r     <= {ADDR_W{1'b0}};
                        busy_r    <= 1'b1;
                        rdata_a_r <= {DATA_W{1'b0}};
                        rdata_b_r <= {DATA_W{1'b0}};
                    end else begin
                        busy_r    <= 1'b0;
                        rdata_a_r <= rd_a_s;
                        rdata_b_r <= rd_b_s;
                    end
                end
                SWEEP: begin
                    rdata_a_r <= {DATA_W{1'b0}};
                    rdata_b_r <= {DATA_W{1'b0}};
                    cnt_r     <= cnt_r + ADDR_W'(1);
                    if (cnt_r == {ADDR_W{1'b1}}) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= {ADDR_W{1'b0}};
                    busy_r    <= 1'b0;
                    rdata_a_r <= {DATA_W{1'b0}};
                    rdata_b_r <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

    // Storage array: the sweep clears it, so it carries no reset of its own.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == SWEEP)) begin
            mem_r[cnt_r] <= {DATA_W{1'b0}};
        end else if (wr_ok_s) begin
            mem_r[waddr] <= merged_s;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign busy    = busy_r;
    assign rdata_a = rdata_a_r;
    assign rdata_b = rdata_b_r;

endmodule
